pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised, handshaked pipeline-stage register. Successor to the fixed-field inter-stage latches between the EX, MEM and WB stages.
- Carries a generic data bundle (PC, inst, ALU result, store data, imm, …) and a separate control bundle (MemWrite, RegWrite, WDSel, DMType, NPCOp, …) across one stage boundary.
- Adds valid/ready flow control with a one-entry skid buffer, synchronous flush with bubble insertion, and a saturating back-pressure counter.

Parameters:
- DATA_W, 160, width of the data bundle (bits).
- CTRL_W, 16, width of the control bundle (bits).
- BUBBLE_CTRL, 0, control value presented whenever the stage holds no valid entry (NOP encoding).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; in_fire = in_valid & in_ready.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  stage presents a valid entry.
- out_ready  in  1  downstream accepts; out_fire = out_valid & out_ready.
- out_data  out  DATA_W  presented data bundle.
- out_ctrl  out  CTRL_W  presented control bundle; BUBBLE_CTRL when out_valid=0.
- flush  in  1  synchronous kill of all held entries (branch/jump redirect).
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Storage: main register (drives outputs) and skid register. All outputs are driven from flops; no combinational path from in_* or out_ready to any output.
- Reset (rst=0, asynchronous):
  - state EMPTY; out_valid=0; in_ready=1.
  - out_data=0; out_ctrl=BUBBLE_CTRL; skid contents 0.
  - occupancy=0; stall_cnt=0.
  - Mid-transfer reset discards all entries with no partial update.
- States: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid). in_ready = (state != FULL).
- Transitions at a rising edge, flush=0:
  - EMPTY: in_fire -> ONE, main<=in. Otherwise stay in EMPTY.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire & !out_fire -> FULL, skid<=in. !in_fire & out_fire -> EMPTY. Neither -> hold.
  - FULL: out_fire -> ONE, main<=skid. in_fire is impossible (in_ready=0). No out_fire -> hold.
- Latency: 1 cycle from in_fire in EMPTY to out_valid. Throughput is one entry per cycle with out_ready held high. Entries leave in strict arrival order; none are lost or duplicated.
- When main becomes empty (->EMPTY), out_ctrl<=BUBBLE_CTRL and out_data holds its last value. Downstream must qualify data with out_valid.
- Flush: synchronous and highest priority. At the edge it forces EMPTY, out_valid=0, out_ctrl=BUBBLE_CTRL and skid valid=0.
  - A concurrent in_fire is dropped.
  - A concurrent out_fire completes downstream (entry consumed), then the stage is empty.
  - in_ready=1 on the cycle after the flush.
- stall_cnt: +1 on each edge where out_valid & !out_ready. Saturates at 2^CNT_W-1 with no wrap. Cleared only by reset; flush does not clear it.
- occupancy equals 0/1/2 for EMPTY/ONE/FULL and updates in the same edge as the state.
- Upstream protocol: in_data/in_ctrl are sampled only on in_fire. Changing them while in_ready=0 has no effect.

Test Plan:
- Streaming: reset, out_ready=1, drive in_data=1..8 on consecutive cycles -> out_data 1..8 on consecutive cycles starting 1 cycle later, occupancy never exceeds 1, stall_cnt=0.
- Back-pressure/skid: send A=0x11, B=0x22 back-to-back with out_ready=0 -> occupancy=2, in_ready=0, C=0x33 held upstream. Raise out_ready -> A, B, C emerge in order, stall_cnt equals the number of low-ready cycles with out_valid=1.
- Flush in FULL: occupancy=2, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, in_ready=1, no held or incoming entry ever appears at the output.
- Flush with out_fire: ONE state, out_ready=1, flush=1 on the same edge -> the entry is counted as consumed once, stage then EMPTY.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt sticks at 15.
- Async reset mid-operation: occupancy=2, pull rst low between edges -> outputs go to reset values immediately. After release, the first new input appears with 1-cycle latency.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with a one-entry skid buffer,
// synchronous flush (bubble insertion) and a saturating stall counter.
// Every output comes from a flop or from a decode of the state flop.
module pipe_stage_skid #(
  parameter int unsigned         DATA_W      = 160,
  parameter int unsigned         CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]   BUBBLE_CTRL = '0,
  parameter int unsigned         CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_fire, out_fire;
  logic              ld_main_in, ld_main_skid, ld_skid, set_bubble;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Status outputs decoded purely from the state register.
  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_n;
  end

  // Next-state and register-load decisions; flush overrides everything.
  always_comb begin
    state_n      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    set_bubble   = 1'b0;
    if (flush) begin
      state_n    = EMPTY;
      set_bubble = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_n    = ONE;
            ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            ld_main_in = 1'b1;
          end else if (in_fire) begin
            state_n = FULL;
            ld_skid = 1'b1;
          end else if (out_fire) begin
            state_n    = EMPTY;
            set_bubble = 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_n      = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // Main (output) and skid registers; out_data keeps its last value on empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_ctrl  <= BUBBLE_CTRL;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (ld_main_in)        out_data <= in_data;
      else if (ld_main_skid) out_data <= skid_data;
      if (set_bubble)        out_ctrl <= BUBBLE_CTRL;
      else if (ld_main_in)   out_ctrl <= in_ctrl;
      else if (ld_main_skid) out_ctrl <= skid_ctrl;
      if (ld_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

  // Saturating count of edges where a valid entry is held back downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
